// File: rtl/sram_ctrl.sv
// sram_ctrl: single-port SRAM access controller.
// The host issues one request at a time (req/we/addr/wdata) while rdy=1.
// The controller then sequences the active-low SRAM strobes through
// SETUP -> ACCESS (TACC cycles) -> HOLD -> DONE and pulses ack for one cycle.
// Optional feature, enabled by defining SRAM_CTRL_WVERIFY_EN: after a write,
// the same location is read back (VACC/VHOLD), and err flags a data mismatch.
// All outputs are registered and are derived from the state being entered.
`timescale 1ns/1ps

module sram_ctrl #(
    parameter int TACC = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req,
    input  logic       we,
    input  logic [4:0] addr,
    input  logic [3:0] wdata,
    output logic       rdy,
    output logic       ack,
    output logic [3:0] rdata,
    output logic       err,
    output logic       s_,
    output logic       mr_,
    output logic       mw_,
    output logic [4:0] mem_addr,
    output logic [3:0] mem_din,
    input  logic [3:0] mem_dout
);

    typedef enum logic [2:0] {
        IDLE, SETUP, ACCESS, HOLD, VACC, VHOLD, DONE
    } state_t;

    // Strobe-phase counter load value: the counter runs TACC-1 down to 0.
    localparam logic [3:0] CNT_LOAD = 4'(TACC - 1);

    state_t     state;
    state_t     next_state;
    logic       op_we;
    logic [3:0] cnt;
    logic       cnt_done;
    logic       accept;

    assign cnt_done = (cnt == 4'd0);
    assign accept   = (state == IDLE) && req;

    // Next-state logic.
    always_comb begin
        // NOTE: default assigned first so every path drives next_state and no latch is inferred.
        next_state = state;
        case (state)
            IDLE:   if (req) next_state = SETUP;
            SETUP:  next_state = ACCESS;
            ACCESS: if (cnt_done) next_state = HOLD;
`ifdef SRAM_CTRL_WVERIFY_EN
            HOLD:   next_state = op_we ? VACC : DONE;
            VACC:   if (cnt_done) next_state = VHOLD;
            VHOLD:  next_state = DONE;
`else
            HOLD:   next_state = DONE;
            VACC:   next_state = IDLE;
            VHOLD:  next_state = IDLE;
`endif
            DONE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register; reset abandons any access in progress.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments for all sequential state so every register samples pre-edge values.
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Request latch, strobe counter, read capture and registered strobes.
    always_ff @(posedge clock) begin
        if (reset) begin
            op_we    <= 1'b0;
            cnt      <= 4'd0;
            mem_addr <= 5'd0;
            mem_din  <= 4'd0;
            rdata    <= 4'd0;
            s_       <= 1'b1;
            mr_      <= 1'b1;
            mw_      <= 1'b1;
            ack      <= 1'b0;
            rdy      <= 1'b1;
        end else begin
            // Address/data only move on acceptance, while s_ is still high.
            if (accept) begin
                op_we    <= we;
                mem_addr <= addr;
                mem_din  <= wdata;
            end

            if ((next_state != state) && (next_state == ACCESS || next_state == VACC))
                cnt <= CNT_LOAD;
            else if (!cnt_done)
                cnt <= cnt - 4'd1;

            if (state == ACCESS && next_state == HOLD && !op_we)
                rdata <= mem_dout;

            // Strobes follow the state being entered, so they line up with it.
            s_  <= (next_state == IDLE) || (next_state == DONE);
            mr_ <= !((next_state == ACCESS && !op_we) || next_state == VACC);
            mw_ <= !(next_state == ACCESS && op_we);
            ack <= (next_state == DONE);
            rdy <= (next_state == IDLE);
        end
    end

`ifdef SRAM_CTRL_WVERIFY_EN
    // Write-verify result: cleared on acceptance, set when read-back differs.
    always_ff @(posedge clock) begin
        if (reset)
            err <= 1'b0;
        else if (accept)
            err <= 1'b0;
        else if (state == VACC && next_state == VHOLD)
            err <= (mem_dout != mem_din);
    end
`else
    // Without write-verify there is nothing to flag.
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: randomized scoreboard bench for sram_ctrl (TACC=2).
// A two-bank 32x4 SRAM model sits downstream. The driver issues requests and
// pushes the expected ack (cycle, rdata, err) computed from a flat reference
// memory; independent monitors check acks and the strobe protocol.
// Define SRAM_CTRL_WVERIFY_EN to exercise write-verify with a stuck-at-0 bit.
`timescale 1ns/1ps

module tb_sram_ctrl;

    localparam int TACC = 2;
`ifdef SRAM_CTRL_WVERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic       clock;
    logic       reset;
    logic       req;
    logic       we;
    logic [4:0] addr;
    logic [3:0] wdata;
    logic       rdy;
    logic       ack;
    logic [3:0] rdata;
    logic       err;
    logic       s_;
    logic       mr_;
    logic       mw_;
    logic [4:0] mem_addr;
    logic [3:0] mem_din;
    logic [3:0] mem_dout;

    sram_ctrl #(.TACC(TACC)) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .rdy      (rdy),
        .ack      (ack),
        .rdata    (rdata),
        .err      (err),
        .s_       (s_),
        .mr_      (mr_),
        .mw_      (mw_),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp_v);
        end
    endtask

    // ---------------- downstream SRAM: two 16x4 banks ----------------
    logic [3:0] bank0 [16];
    logic [3:0] bank1 [16];
    bit         stuck0 = 1'b0;

    always @(posedge clock) begin
        if (!s_ && !mw_) begin
            if (mem_addr[4]) bank1[mem_addr[3:0]] <= stuck0 ? (mem_din & 4'hE) : mem_din;
            else             bank0[mem_addr[3:0]] <= stuck0 ? (mem_din & 4'hE) : mem_din;
        end
    end

    assign mem_dout = (!s_ && !mr_) ? (mem_addr[4] ? bank1[mem_addr[3:0]] : bank0[mem_addr[3:0]])
                                    : 4'h0;

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        bit         is_read;
        logic [3:0] data;
        bit         err;
        int         ack_cyc;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] ref_mem [32];
    logic [3:0] last_rd;

    function automatic logic [3:0] stored_value(input logic [3:0] d);
        return stuck0 ? (d & 4'hE) : d;
    endfunction

    // Issue one request from a negedge; req stays high for 'hold' cycles.
    task automatic do_op(input bit w, input logic [4:0] a, input logic [3:0] d, input int hold);
        exp_t e;
        int   n;
        n = 0;
        while (!rdy && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!rdy) begin
            check("rdy_timeout", rdy, 1);
            return;
        end
        we    = w;
        addr  = a;
        wdata = d;
        req   = 1'b1;
        e.is_read = !w;
        e.ack_cyc = cyc + 1 + ((w && VERIFY) ? (2 * TACC + 3) : (TACC + 2));
        if (w) begin
            ref_mem[a] = stored_value(d);
            e.err      = VERIFY && (ref_mem[a] != d);
            e.data     = last_rd;
        end else begin
            e.err   = 1'b0;
            e.data  = ref_mem[a];
            last_rd = ref_mem[a];
        end
        sb.push_back(e);
        @(negedge clock);
        for (int i = 1; i < hold; i++) begin
            we    = 1'($urandom);
            addr  = 5'($urandom);
            wdata = 4'($urandom);
            @(negedge clock);
        end
        req = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || !rdy) && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("drain_timeout", (sb.size() == 0 && rdy) ? 1 : 0, 1);
    endtask

    // ---------------- ack monitor ----------------
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (!reset && ack) begin
            if (sb.size() == 0) begin
                check("spurious_ack", 1, 0);
            end else begin
                e = sb.pop_front();
                check("ack_latency", cyc, e.ack_cyc);
                check(e.is_read ? "read_data" : "rdata_hold", rdata, e.data);
                check("err_flag", err, e.err);
            end
        end
    end

    // ---------------- strobe protocol monitor ----------------
    int         mr_run = 0;
    int         mw_run = 0;
    logic       prev_s = 1'b1;
    logic [4:0] prev_addr = 5'd0;
    logic [3:0] prev_din = 4'd0;

    always @(posedge clock) begin
        #1;
        if (reset) begin
            mr_run = 0;
            mw_run = 0;
        end else begin
            check("strobe_overlap", (!mr_ && !mw_) ? 1 : 0, 0);
            check("strobe_without_select", (s_ && (!mr_ || !mw_)) ? 1 : 0, 0);
            if (!prev_s && !s_)
                check("addr_din_stable", {prev_addr, prev_din} == {mem_addr, mem_din} ? 1 : 0, 1);
            check("rdy_vs_ack", (rdy && ack) ? 1 : 0, 0);
            if (!mr_) mr_run++;
            else if (mr_run > 0) begin
                check("mr_width", mr_run, TACC);
                mr_run = 0;
            end
            if (!mw_) mw_run++;
            else if (mw_run > 0) begin
                check("mw_width", mw_run, TACC);
                mw_run = 0;
            end
        end
        prev_s    = s_;
        prev_addr = mem_addr;
        prev_din  = mem_din;
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        for (int i = 0; i < 16; i++) begin
            bank0[i] = 4'h0;
            bank1[i] = 4'h0;
        end
        for (int i = 0; i < 32; i++) ref_mem[i] = 4'h0;
        last_rd = 4'h0;

        // Reset with a competing request: reset must win.
        reset = 1'b1;
        req   = 1'b1;
        we    = 1'b1;
        addr  = 5'h1F;
        wdata = 4'hF;
        repeat (3) @(negedge clock);
        check("rst_rdy", rdy, 1);
        check("rst_s", s_, 1);
        check("rst_mr", mr_, 1);
        check("rst_mw", mw_, 1);
        check("rst_ack", ack, 0);
        check("rst_err", err, 0);
        check("rst_rdata", rdata, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_din", mem_din, 0);
        reset = 1'b0;
        req   = 1'b0;
        @(negedge clock);
        check("idle_after_rst", rdy, 1);

        // Write then read in bank 1.
        do_op(1'b1, 5'h13, 4'hA, 1);
        do_op(1'b0, 5'h13, 4'h0, 1);
        // Same low address in both banks.
        do_op(1'b1, 5'h03, 4'h5, 1);
        do_op(1'b1, 5'h13, 4'hC, 1);
        do_op(1'b0, 5'h03, 4'h0, 1);
        do_op(1'b0, 5'h13, 4'h0, 1);
        // Request held high through the whole access.
        do_op(1'b0, 5'h03, 4'h0, TACC + 2);
        do_op(1'b1, 5'h1E, 4'h9, TACC + 2);
        drain();

        // Reset in the middle of a write's ACCESS phase.
        do_op(1'b1, 5'h0A, 4'h6, 1);
        n = 0;
        while (mw_ && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("mw_seen_before_reset", mw_, 0);
        void'(sb.pop_back());
        last_rd = 4'h0;
        reset = 1'b1;
        req   = 1'b1;
        we    = 1'b0;
        @(negedge clock);
        check("abort_s", s_, 1);
        check("abort_mw", mw_, 1);
        check("abort_rdy", rdy, 1);
        check("abort_ack", ack, 0);
        check("abort_rdata", rdata, 0);
        reset = 1'b0;
        req   = 1'b0;
        @(negedge clock);
        do_op(1'b0, 5'h0A, 4'h0, 1);
        drain();

        // Randomized traffic.
        for (int i = 0; i < 80; i++)
            do_op(1'($urandom), 5'($urandom), 4'($urandom), $urandom_range(1, TACC + 2));
        drain();

`ifdef SRAM_CTRL_WVERIFY_EN
        // Bit 0 stuck at 0: 0x7 reads back wrong, 0x6 reads back right.
        stuck0 = 1'b1;
        do_op(1'b1, 5'h15, 4'h7, 1);
        do_op(1'b0, 5'h15, 4'h0, 1);
        do_op(1'b1, 5'h05, 4'h6, 1);
        do_op(1'b0, 5'h05, 4'h0, 1);
        for (int i = 0; i < 20; i++)
            do_op(1'($urandom), 5'($urandom), 4'($urandom), 1);
        drain();
        stuck0 = 1'b0;
`endif

        check("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
